mem_arbiter: RTL

Two-port round-robin arbiter that shares the single valid/ready memory block (WIDTH×DEPTH, one transaction at a time) between two requesters. Each requester gets its own valid/ready port. The arbiter latches the winning request, drives it to the memory, and waits for the memory's ready. It then returns a one-cycle ready, with read data or an error, to the winner. A watchdog aborts transactions the memory never acknowledges.

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared memory.
// Signal suffixes are from the arbiter's point of view; slave = arbiter side.
interface mem_arbiter_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  s0_valid_i;
  logic                  s0_wr_rd_i;
  logic [ADDR_WIDTH-1:0] s0_addr_i;
  logic [WIDTH-1:0]      s0_wdata_i;
  logic                  s0_ready_o;
  logic [WIDTH-1:0]      s0_rdata_o;
  logic                  s0_err_o;

  logic                  s1_valid_i;
  logic                  s1_wr_rd_i;
  logic [ADDR_WIDTH-1:0] s1_addr_i;
  logic [WIDTH-1:0]      s1_wdata_i;
  logic                  s1_ready_o;
  logic [WIDTH-1:0]      s1_rdata_o;
  logic                  s1_err_o;

  logic                  mem_valid_o;
  logic                  mem_wr_rd_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]      mem_wdata_o;
  logic                  mem_ready_i;
  logic [WIDTH-1:0]      mem_rdata_i;

  logic [1:0]            grant_o;

  modport slave (
    input  s0_valid_i, s0_wr_rd_i, s0_addr_i, s0_wdata_i,
    output s0_ready_o, s0_rdata_o, s0_err_o,
    input  s1_valid_i, s1_wr_rd_i, s1_addr_i, s1_wdata_i,
    output s1_ready_o, s1_rdata_o, s1_err_o,
    output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i,
    output grant_o
  );

  modport master (
    output s0_valid_i, s0_wr_rd_i, s0_addr_i, s0_wdata_i,
    input  s0_ready_o, s0_rdata_o, s0_err_o,
    output s1_valid_i, s1_wr_rd_i, s1_addr_i, s1_wdata_i,
    input  s1_ready_o, s1_rdata_o, s1_err_o,
    input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i,
    input  grant_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single valid/ready memory,
// with a watchdog that aborts transactions the memory never acknowledges.
//
// state | meaning
// IDLE  | no owner; arbitrate and latch the winning request
// BUSY  | mem_valid_o high, waiting for mem_ready_i or watchdog expiry
// RESP  | one-cycle ready (with rdata/err) to the owner
module mem_arbiter #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_q,      state_d;
  logic                  last_grant_q, last_grant_d;
  logic [1:0]            grant_q,      grant_d;
  logic [CNT_WIDTH-1:0]  cnt_q,        cnt_d;
  logic                  wr_rd_q,      wr_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [WIDTH-1:0]      wdata_q,      wdata_d;
  logic [WIDTH-1:0]      rdata_q,      rdata_d;
  logic                  err_q,        err_d;
  logic [1:0]            ready_q,      ready_d;

  logic pick1;

  // Port 1 wins when it is alone, or on a tie when port 0 was granted last.
  assign pick1 = bus.s1_valid_i & (~bus.s0_valid_i | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    wr_rd_d      = wr_rd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    ready_d      = 2'b00;

    case (state_q)
      IDLE: begin
        if (bus.s0_valid_i || bus.s1_valid_i) begin
          state_d      = BUSY;
          last_grant_d = pick1;
          grant_d      = pick1 ? 2'b10 : 2'b01;
          cnt_d        = '0;
          wr_rd_d      = pick1 ? bus.s1_wr_rd_i : bus.s0_wr_rd_i;
          addr_d       = pick1 ? bus.s1_addr_i  : bus.s0_addr_i;
          wdata_d      = pick1 ? bus.s1_wdata_i : bus.s0_wdata_i;
        end
      end
      BUSY: begin
        // An acknowledge on the watchdog's last cycle still counts as success.
        if (bus.mem_ready_i) begin
          state_d = RESP;
          rdata_d = wr_rd_q ? '0 : bus.mem_rdata_i;
          err_d   = 1'b0;
          ready_d = grant_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          ready_d = grant_q;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      cnt_q        <= '0;
      wr_rd_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      ready_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      wr_rd_q      <= wr_rd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.mem_valid_o = (state_q == BUSY);
  assign bus.mem_wr_rd_o = wr_rd_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.grant_o     = grant_q;

  // Response fields are only presented to the port that is being answered.
  assign bus.s0_ready_o = ready_q[0];
  assign bus.s0_rdata_o = ready_q[0] ? rdata_q : '0;
  assign bus.s0_err_o   = ready_q[0] & err_q;
  assign bus.s1_ready_o = ready_q[1];
  assign bus.s1_rdata_o = ready_q[1] ? rdata_q : '0;
  assign bus.s1_err_o   = ready_q[1] & err_q;

endmodule
